// File: rtl/hazard_fwd_if.sv
// hazard_fwd_if: ID-stage hazard query and forwarding select bundle.
// master = pipeline control driving ID fields, slave = hazard_fwd_unit.
interface hazard_fwd_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic            id_valid;
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic            id_rs_used;
  logic            id_rt_used;
  logic [RA_W-1:0] id_rd;
  logic            id_regwrite;
  logic            id_memread;
  logic            flush;
  logic            stall;
  logic [1:0]      fwd_a_sel;
  logic [1:0]      fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt,
    output id_rs_used, id_rt_used,
    output id_rd, id_regwrite, id_memread,
    output flush,
    input  stall, fwd_a_sel, fwd_b_sel,
    input  stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt,
    input  id_rs_used, id_rt_used,
    input  id_rd, id_regwrite, id_memread,
    input  flush,
    output stall, fwd_a_sel, fwd_b_sel,
    output stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: RAW hazard stall and EX operand forwarding selects.
// HFU_FORWARD_EN defined: forwarding; undefined: full interlock.
module hazard_fwd_unit #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst_n,
  hazard_fwd_if.slave hif
);

  // The MEM slot seen at ID time is the WB stage once the consumer
  // reaches EX, so EX and MEM tags cover every forwarding source.
  logic            ex_vld_q;
  logic            ex_rw_q;
  logic [RA_W-1:0] ex_rd_q;
  logic            mem_vld_q;
  logic            mem_rw_q;
  logic [RA_W-1:0] mem_rd_q;
  logic [CNT_W-1:0] cnt_q;

  logic ex_a, ex_b;
  logic mem_a, mem_b;
  logic live;
  logic stall_w;
  logic bubble;

  function automatic logic writes(
    input logic            v,
    input logic            rw,
    input logic [RA_W-1:0] rd,
    input logic [RA_W-1:0] r
  );
    return v & rw & (rd == r) & (r != '0);
  endfunction

  assign ex_a  = hif.id_rs_used &
                 writes(ex_vld_q, ex_rw_q, ex_rd_q, hif.id_rs);
  assign ex_b  = hif.id_rt_used &
                 writes(ex_vld_q, ex_rw_q, ex_rd_q, hif.id_rt);
  assign mem_a = hif.id_rs_used &
                 writes(mem_vld_q, mem_rw_q, mem_rd_q, hif.id_rs);
  assign mem_b = hif.id_rt_used &
                 writes(mem_vld_q, mem_rw_q, mem_rd_q, hif.id_rt);

  assign live   = hif.id_valid & ~hif.flush;
  assign bubble = stall_w | ~live;

`ifdef HFU_FORWARD_EN
  logic       ex_ld_q;
  logic [1:0] sel_a_q, sel_a_d;
  logic [1:0] sel_b_q, sel_b_d;

  // Only a load in EX cannot be forwarded in time.
  assign stall_w = live & ex_ld_q & (ex_a | ex_b);

  // Newer producer (EX) wins over MEM; bubbles read the register file.
  always_comb begin
    sel_a_d = 2'b00;
    sel_b_d = 2'b00;
    if (!bubble) begin
      if (ex_a)       sel_a_d = 2'b01;
      else if (mem_a) sel_a_d = 2'b10;
      if (ex_b)       sel_b_d = 2'b01;
      else if (mem_b) sel_b_d = 2'b10;
    end
  end

  // Load flag and selects follow the instruction into EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ld_q <= 1'b0;
      sel_a_q <= 2'b00;
      sel_b_q <= 2'b00;
    end else begin
      ex_ld_q <= ~bubble & hif.id_memread;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign hif.fwd_a_sel = sel_a_q;
  assign hif.fwd_b_sel = sel_b_q;
`else
  // No bypass paths: wait until the producer has left MEM.
  assign stall_w = live & (ex_a | ex_b | mem_a | mem_b);

  assign hif.fwd_a_sel = 2'b00;
  assign hif.fwd_b_sel = 2'b00;
`endif

  // Tag pipeline shifts every cycle; ID loads a bubble when held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_vld_q  <= 1'b0;
      ex_rw_q   <= 1'b0;
      ex_rd_q   <= '0;
      mem_vld_q <= 1'b0;
      mem_rw_q  <= 1'b0;
      mem_rd_q  <= '0;
    end else begin
      mem_vld_q <= ex_vld_q;
      mem_rw_q  <= ex_rw_q;
      mem_rd_q  <= ex_rd_q;
      ex_vld_q  <= ~bubble;
      ex_rw_q   <= ~bubble & hif.id_regwrite;
      ex_rd_q   <= bubble ? '0 : hif.id_rd;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (stall_w && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hif.stall     = stall_w;
  assign hif.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed vectors for hazard_fwd_unit.
// Expectations follow HFU_FORWARD_EN when defined, interlock otherwise.
module tb_hazard_fwd_unit;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef HFU_FORWARD_EN
  localparam int NST = 1;
`else
  localparam int NST = 2;
`endif

  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;
  int   exp_cnt;

  hazard_fwd_if #(.RA_W(5), .CNT_W(CW)) hif ();

  hazard_fwd_unit #(.RA_W(5), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(
    input bit v, input int rd, input bit rw, input bit mr,
    input int rs, input bit rsu, input int rt, input bit rtu,
    input bit fl
  );
    hif.id_valid    = v;
    hif.id_rd       = 5'(rd);
    hif.id_regwrite = rw;
    hif.id_memread  = mr;
    hif.id_rs       = 5'(rs);
    hif.id_rs_used  = rsu;
    hif.id_rt       = 5'(rt);
    hif.id_rt_used  = rtu;
    hif.flush       = fl;
  endtask

  // One ID cycle: check stall mid-cycle, then cross the edge.
  task automatic step(
    input string tag,
    input bit v, input int rd, input bit rw, input bit mr,
    input int rs, input bit rsu, input int rt, input bit rtu,
    input bit fl, input bit xs
  );
    drive(v, rd, rw, mr, rs, rsu, rt, rtu, fl);
    #1;
    check({tag, "/stall"}, int'(hif.stall), int'(xs));
    @(posedge clk);
    #1;
    if (xs && exp_cnt != CMAX) exp_cnt++;
  endtask

  task automatic alu(
    input string tag, input int rd, input int rs, input int rt,
    input bit xs
  );
    step(tag, 1, rd, 1, 0, rs, 1, rt, 1, 0, xs);
  endtask

  task automatic ld(input string tag, input int rd, input int rs,
                    input bit xs);
    step(tag, 1, rd, 1, 1, rs, 1, 0, 0, 0, xs);
  endtask

  task automatic nop();
    step("nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic sels(input string tag, input int a, input int b);
    check({tag, "/sel_a"}, int'(hif.fwd_a_sel), a);
    check({tag, "/sel_b"}, int'(hif.fwd_b_sel), b);
  endtask

  task automatic cnt(input string tag);
    check({tag, "/cnt"}, int'(hif.stall_cnt), exp_cnt);
  endtask

  initial begin
    n_run   = 0;
    n_fail  = 0;
    exp_cnt = 0;
    rst_n   = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #2;
    check("rst/stall", int'(hif.stall), 0);
    sels("rst", 0, 0);
    cnt("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef HFU_FORWARD_EN
    alu("add3", 3, 1, 2, 0);
    alu("sub4", 4, 3, 3, 0);
    sels("ex2ex", 1, 1);
    nop(); nop();
    alu("add3", 3, 1, 2, 0);
    nop();
    alu("or6", 6, 3, 0, 0);
    sels("two_ahead", 2, 0);
    nop(); nop();
    alu("add3", 3, 1, 2, 0);
    alu("add3b", 3, 1, 2, 0);
    alu("or6", 6, 3, 0, 0);
    sels("newest", 1, 0);
    nop(); nop();
    ld("lw2", 2, 1, 0);
    alu("add7", 7, 2, 1, 1);
    sels("lu_bubble", 0, 0);
    alu("add7", 7, 2, 1, 0);
    sels("lu_fwd", 2, 0);
    cnt("lu");
    nop(); nop();
`else
    alu("add3", 3, 1, 2, 0);
    alu("sub4", 4, 3, 1, 1);
    sels("il_s1", 0, 0);
    alu("sub4", 4, 3, 1, 1);
    alu("sub4", 4, 3, 1, 0);
    sels("il_go", 0, 0);
    cnt("il");
    nop(); nop();
    ld("lw2", 2, 1, 0);
    alu("add7", 7, 2, 1, 1);
    alu("add7", 7, 2, 1, 1);
    alu("add7", 7, 2, 1, 0);
    sels("il_lu", 0, 0);
    cnt("il_lu");
    nop(); nop();
    alu("add5", 5, 1, 2, 0);
    nop();
    alu("memhaz", 6, 5, 1, 1);
    alu("memhaz", 6, 5, 1, 0);
    cnt("memhaz");
    nop(); nop();
`endif

    ld("lw2f", 2, 1, 0);
    step("flush", 1, 7, 1, 0, 2, 1, 1, 1, 1, 0);
    sels("flush", 0, 0);
    cnt("flush");
    alu("add0", 0, 1, 1, 0);
    alu("r0use", 1, 0, 0, 0);
    sels("r0", 0, 0);
    nop();
    ld("lw1", 1, 3, 0);
    step("inval", 0, 9, 1, 1, 1, 1, 1, 1, 0, 0);
    sels("inval", 0, 0);
    ld("lw3", 3, 2, 0);
    step("unused", 1, 8, 1, 0, 3, 0, 0, 1, 0, 0);
    sels("unused", 0, 0);
    nop(); nop();

    alu("add4", 4, 1, 2, 0);
    ld("lw3r", 3, 1, 0);
    drive(1, 6, 1, 0, 5, 1, 3, 1, 0);
    #1;
    check("pre_rst/stall", int'(hif.stall), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst/stall", int'(hif.stall), 0);
    sels("mid_rst", 0, 0);
    exp_cnt = 0;
    cnt("mid_rst");
    #1 rst_n = 1'b1;
    alu("post_rst", 6, 5, 3, 0);
    sels("post_rst", 0, 0);

    for (int i = 0; i < 16 / NST; i++) begin
      ld("sat_ld", 3, 1, 0);
      for (int k = 0; k <= NST; k++) begin
        alu("sat_use", 4, 3, 1, k < NST);
      end
      cnt("sat");
    end
    check("sat/final", int'(hif.stall_cnt), CMAX);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
